alu_ctrl_seq: RTL and testbench

// - Parametrised successor to the combinational ALU-select decoder: decodes alu_op/funct,

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/muldiv_iter.sv | 67 ++++++
 rtl/alu_ctrl_seq.sv | 165 ++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control sequencer: alu_op, funct and select codes,
// and the FSM state type.
package alu_pkg;

  localparam logic [1:0] AOP_MEM   = 2'b00;
  localparam logic [1:0] AOP_BEQ   = 2'b01;
  localparam logic [1:0] AOP_RTYPE = 2'b10;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_MULT = 6'b011000;
  localparam logic [5:0] F_DIV  = 6'b011010;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;

  // Low 3 bits of the legacy codes (AND/OR/ADD/SUB/SLT) are preserved.
  localparam logic [3:0] SEL_AND  = 4'b0000;
  localparam logic [3:0] SEL_OR   = 4'b0001;
  localparam logic [3:0] SEL_ADD  = 4'b0010;
  localparam logic [3:0] SEL_XOR  = 4'b0011;
  localparam logic [3:0] SEL_SUB  = 4'b0110;
  localparam logic [3:0] SEL_SLT  = 4'b0111;
  localparam logic [3:0] SEL_SLL  = 4'b1000;
  localparam logic [3:0] SEL_SRL  = 4'b1001;
  localparam logic [3:0] SEL_MULT = 4'b1010;
  localparam logic [3:0] SEL_DIV  = 4'b1011;
  localparam logic [3:0] SEL_NOR  = 4'b1100;
  localparam logic [3:0] SEL_MFHI = 4'b1101;
  localparam logic [3:0] SEL_MFLO = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle unsigned multiplier / restoring divider sharing one {hi,lo} register pair.
// done is raised during the last iteration; hi/lo then carry that iteration's final values.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic             busy_q, mode_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] opd_q, hi_q, lo_q, hi_nx, lo_nx;
  logic [WIDTH:0]   add_sum, shl, diff;
  logic             ge;

  // mode 0: shift-add multiply (opd = multiplicand); mode 1: restoring divide (opd = divisor)
  always_comb begin
    add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    shl     = {hi_q, lo_q[WIDTH-1]};
    diff    = shl - {1'b0, opd_q};
    ge      = (shl >= {1'b0, opd_q});
    hi_nx   = hi_q;
    lo_nx   = lo_q;
    if (!mode_q) begin
      {hi_nx, lo_nx} = {add_sum, lo_q[WIDTH-1:1]};
    end else begin
      hi_nx = ge ? diff[WIDTH-1:0] : shl[WIDTH-1:0];
      lo_nx = {lo_q[WIDTH-2:0], ge};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
      opd_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      mode_q <= mode;
      cnt_q  <= CW'(WIDTH);
      hi_q   <= '0;
      lo_q   <= mode ? a : b;
      opd_q  <= mode ? b : a;
    end else if (busy_q) begin
      hi_q  <= hi_nx;
      lo_q  <= lo_nx;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

  assign done = busy_q && (cnt_q == CW'(1));
  assign hi   = hi_nx;
  assign lo   = lo_nx;

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: decodes alu_op/funct, runs single-cycle ALU ops or an iterative
// MULT/DIV, and returns a registered result over a valid/ready handshake.
//   state | meaning
//   IDLE  | accepting requests; single-cycle results complete here
//   BUSY  | MULT/DIV engine iterating
//   DONE  | MULT/DIV result held until consumed
module alu_ctrl_seq
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SELW      = 4,
  parameter int MULDIV_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err,
  output logic [SELW-1:0]  select
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic MD = (MULDIV_EN != 0);

  state_t           state_q, state_nx;
  logic [3:0]       dec_sel, pend_sel;
  logic             dec_ill, dec_md, accept, eng_done;
  logic [WIDTH-1:0] alu_res, hi_q, lo_q, eng_hi, eng_lo;
  logic             out_valid_q, zero_q, err_q;
  logic [WIDTH-1:0] result_q;
  logic [SELW-1:0]  select_q;

  always_comb begin
    dec_sel = SEL_ADD;
    dec_ill = 1'b0;
    dec_md  = 1'b0;
    case (alu_op)
      AOP_MEM: dec_sel = SEL_ADD;
      AOP_BEQ: dec_sel = SEL_SUB;
      AOP_RTYPE: begin
        case (funct)
          F_ADD:  dec_sel = SEL_ADD;
          F_SUB:  dec_sel = SEL_SUB;
          F_AND:  dec_sel = SEL_AND;
          F_OR:   dec_sel = SEL_OR;
          F_XOR:  dec_sel = SEL_XOR;
          F_NOR:  dec_sel = SEL_NOR;
          F_SLT:  dec_sel = SEL_SLT;
          F_SLL:  dec_sel = SEL_SLL;
          F_SRL:  dec_sel = SEL_SRL;
          F_MULT: begin dec_sel = SEL_MULT; dec_md = MD; dec_ill = !MD; end
          F_DIV:  begin dec_sel = SEL_DIV;  dec_md = MD; dec_ill = !MD; end
          F_MFHI: begin dec_sel = SEL_MFHI; dec_ill = !MD; end
          F_MFLO: begin dec_sel = SEL_MFLO; dec_ill = !MD; end
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) dec_sel = SEL_ADD;
  end

  always_comb begin
    alu_res = '0;
    case (dec_sel)
      SEL_AND:  alu_res = a & b;
      SEL_OR:   alu_res = a | b;
      SEL_ADD:  alu_res = a + b;
      SEL_XOR:  alu_res = a ^ b;
      SEL_NOR:  alu_res = ~(a | b);
      SEL_SUB:  alu_res = a - b;
      SEL_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      SEL_SLL:  alu_res = a << b[SHW-1:0];
      SEL_SRL:  alu_res = a >> b[SHW-1:0];
      SEL_MFHI: alu_res = hi_q;
      SEL_MFLO: alu_res = lo_q;
      default:  alu_res = '0;
    endcase
  end

  assign in_ready = !rst && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  generate
    if (MULDIV_EN != 0) begin : g_md
      muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (accept && dec_md),
        .mode  (dec_sel == SEL_DIV),
        .a     (a),
        .b     (b),
        .done  (eng_done),
        .hi    (eng_hi),
        .lo    (eng_lo)
      );
    end else begin : g_no_md
      assign eng_done = 1'b0;
      assign eng_hi   = '0;
      assign eng_lo   = '0;
    end
  endgenerate

  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE: if (accept && dec_md) state_nx = ST_BUSY;
      ST_BUSY: if (eng_done) state_nx = ST_DONE;
      ST_DONE: if (out_valid_q && out_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nx;
  end

  // A newly completed op takes priority over retiring the held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      err_q       <= 1'b0;
      select_q    <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      pend_sel    <= SEL_ADD;
    end else begin
      if (state_q == ST_BUSY && eng_done) begin
        hi_q        <= eng_hi;
        lo_q        <= eng_lo;
        result_q    <= eng_lo;
        zero_q      <= (eng_lo == '0);
        err_q       <= 1'b0;
        select_q    <= SELW'(pend_sel);
        out_valid_q <= 1'b1;
      end else if (accept && !dec_md) begin
        result_q    <= dec_ill ? '0 : alu_res;
        zero_q      <= dec_ill || (alu_res == '0);
        err_q       <= dec_ill;
        select_q    <= SELW'(dec_sel);
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept && dec_md) pend_sel <= dec_sel;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign err       = err_q;
  assign select    = select_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed spec cases plus randomized ops
// checked against an arithmetic reference model with its own hi/lo state.
module tb_alu_ctrl_seq;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, zero, err;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] a, b, result;
  logic [3:0]  select;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_hi = 32'h0, m_lo = 32'h0;

  alu_ctrl_seq #(.WIDTH(32), .SELW(4), .MULDIV_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .err(err), .select(select)
  );

  always #5 clk = ~clk;

  // Reference model: spec rules in plain arithmetic, tracks hi/lo itself.
  task automatic model(input logic [1:0] op, input logic [5:0] f, input logic [31:0] av, bv,
                       output logic [31:0] r, output logic e, output logic [3:0] s, output int lat);
    logic [63:0] p;
    r = 32'h0; e = 1'b0; s = 4'h2; lat = 1;
    if (op == 2'b00) r = av + bv;
    else if (op == 2'b01) begin r = av - bv; s = 4'h6; end
    else if (op == 2'b11) e = 1'b1;
    else begin
      case (f)
        6'h20: begin r = av + bv;     s = 4'h2; end
        6'h22: begin r = av - bv;     s = 4'h6; end
        6'h24: begin r = av & bv;     s = 4'h0; end
        6'h25: begin r = av | bv;     s = 4'h1; end
        6'h26: begin r = av ^ bv;     s = 4'h3; end
        6'h27: begin r = ~(av | bv);  s = 4'hC; end
        6'h2A: begin r = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0; s = 4'h7; end
        6'h00: begin r = av << bv[4:0]; s = 4'h8; end
        6'h02: begin r = av >> bv[4:0]; s = 4'h9; end
        6'h10: begin r = m_hi; s = 4'hD; end
        6'h12: begin r = m_lo; s = 4'hE; end
        6'h18: begin
          p = {32'h0, av} * {32'h0, bv};
          m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo; s = 4'hA; lat = 33;
        end
        6'h1A: begin
          if (bv == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = av; end
          else begin m_lo = av / bv; m_hi = av % bv; end
          r = m_lo; s = 4'hB; lat = 33;
        end
        default: e = 1'b1;
      endcase
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [31:0] av, bv,
                       output int lat);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL issue_ready: in_ready=%b required 1", in_ready); end
    alu_op = op; funct = f; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; alu_op = 2'b00; funct = 6'h0; a = 0; b = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low: got %b required 0", in_ready); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, zero, err, select, result} !== {1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b ov=%b z=%b e=%b sel=%h res=%h required 1 0 1 0 0 0",
               in_ready, out_valid, zero, err, select, result);
    end
    m_hi = 0; m_lo = 0;
  endtask

  task automatic test_basic();
    int lat; logic [31:0] r; logic e; logic [3:0] s; int ml;
    issue(2'b10, 6'h20, 32'd5, 32'd7, lat);
    model(2'b10, 6'h20, 32'd5, 32'd7, r, e, s, ml);
    n_checks++;
    if ({lat, result, zero, select} !== {32'd1, 32'd12, 1'b0, 4'h2}) begin
      n_fail++; $display("FAIL add_5_7: lat=%0d res=%0d z=%b sel=%h required 1 12 0 2", lat, result, zero, select);
    end
    issue(2'b01, 6'h00, 32'h1234, 32'h1234, lat);
    n_checks++;
    if ({result, zero, select} !== {32'h0, 1'b1, 4'h6}) begin
      n_fail++; $display("FAIL beq_sub: res=%h z=%b sel=%h required 0 1 6", result, zero, select);
    end
    issue(2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1, lat);
    n_checks++;
    if ({result, select} !== {32'd1, 4'h7}) begin
      n_fail++; $display("FAIL slt_signed: res=%h sel=%h required 1 7", result, select);
    end
  endtask

  task automatic test_muldiv();
    int lat; logic [31:0] r; logic e; logic [3:0] s; int ml;
    issue(2'b10, 6'h18, 32'hFFFF_FFFF, 32'd2, lat);
    model(2'b10, 6'h18, 32'hFFFF_FFFF, 32'd2, r, e, s, ml);
    n_checks++;
    if ({lat, result, select, err} !== {32'd33, 32'hFFFF_FFFE, 4'hA, 1'b0}) begin
      n_fail++; $display("FAIL mult_max: lat=%0d res=%h sel=%h err=%b required 33 fffffffe a 0", lat, result, select, err);
    end
    issue(2'b10, 6'h10, 32'h0, 32'h0, lat);
    n_checks++;
    if (result !== 32'd1) begin n_fail++; $display("FAIL mfhi_after_mult: got %h required 1", result); end
    issue(2'b10, 6'h1A, 32'd100, 32'd7, lat);
    model(2'b10, 6'h1A, 32'd100, 32'd7, r, e, s, ml);
    n_checks++;
    if ({lat, result, select} !== {32'd33, 32'd14, 4'hB}) begin
      n_fail++; $display("FAIL div_100_7: lat=%0d lo=%0d sel=%h required 33 14 b", lat, result, select);
    end
    issue(2'b10, 6'h10, 32'h0, 32'h0, lat);
    n_checks++;
    if (result !== 32'd2) begin n_fail++; $display("FAIL div_rem: got %0d required 2", result); end
    issue(2'b10, 6'h1A, 32'd9, 32'd0, lat);
    model(2'b10, 6'h1A, 32'd9, 32'd0, r, e, s, ml);
    n_checks++;
    if ({lat, result, err} !== {32'd33, 32'hFFFF_FFFF, 1'b0}) begin
      n_fail++; $display("FAIL div_by_zero: lat=%0d lo=%h err=%b required 33 ffffffff 0", lat, result, err);
    end
    issue(2'b10, 6'h10, 32'h0, 32'h0, lat);
    n_checks++;
    if (result !== 32'd9) begin n_fail++; $display("FAIL div0_hi: got %0d required 9", result); end
  endtask

  task automatic test_illegal();
    int lat;
    issue(2'b10, 6'h3F, 32'd3, 32'd4, lat);
    n_checks++;
    if ({err, result, zero, select} !== {1'b1, 32'h0, 1'b1, 4'h2}) begin
      n_fail++; $display("FAIL illegal_funct: err=%b res=%h z=%b sel=%h required 1 0 1 2", err, result, zero, select);
    end
    issue(2'b11, 6'h20, 32'd3, 32'd4, lat);
    n_checks++;
    if ({err, result, zero} !== {1'b1, 32'h0, 1'b1}) begin
      n_fail++; $display("FAIL illegal_aluop: err=%b res=%h z=%b required 1 0 1", err, result, zero);
    end
    issue(2'b10, 6'h10, 32'h0, 32'h0, lat);
    n_checks++;
    if ({err, result} !== {1'b0, m_hi}) begin
      n_fail++; $display("FAIL illegal_hi_kept: err=%b hi=%h required 0 %h", err, result, m_hi);
    end
    issue(2'b10, 6'h12, 32'h0, 32'h0, lat);
    n_checks++;
    if (result !== m_lo) begin n_fail++; $display("FAIL illegal_lo_kept: lo=%h required %h", result, m_lo); end
  endtask

  task automatic test_random();
    logic [5:0] fl [14];
    logic [1:0] op; logic [5:0] f; logic [31:0] av, bv, r; logic e; logic [3:0] s;
    int lat, ml, pick;
    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02,
           6'h18, 6'h1A, 6'h10, 6'h12, 6'h3B};
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) op = 2'b10;
      pick = $urandom_range(0, 13);
      f = fl[pick];
      av = $urandom(); bv = $urandom();
      if ($urandom_range(0, 3) == 0) bv = bv >> 24;
      issue(op, f, av, bv, lat);
      model(op, f, av, bv, r, e, s, ml);
      n_checks++;
      if ({lat, result, zero, err, select} !== {ml, r, (r == 32'h0) || e, e, s}) begin
        n_fail++;
        $display("FAIL random_op[%0d] op=%b f=%h a=%h b=%h: lat=%0d res=%h z=%b e=%b sel=%h required %0d %h %b %b %h",
                 i, op, f, av, bv, lat, result, zero, err, select, ml, r, (r == 32'h0) || e, e, s);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] av, bv, r; logic e; logic [3:0] s; int ml;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b required 1", i, in_ready); end
      av = $urandom(); bv = $urandom();
      alu_op = 2'b10; funct = (i % 2 == 0) ? 6'h26 : 6'h22; a = av; b = bv; in_valid = 1'b1;
      model(2'b10, funct, av, bv, r, e, s, ml);
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, result} !== {1'b1, r}) begin
        n_fail++; $display("FAIL b2b_result[%0d]: ov=%b res=%h required 1 %h", i, out_valid, result, r);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] r; logic e; logic [3:0] s; int ml;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    issue(2'b10, 6'h25, 32'hF0F0_0000, 32'h0000_0F0F, lat);
    model(2'b10, 6'h25, 32'hF0F0_0000, 32'h0000_0F0F, r, e, s, ml);
    in_valid = 1'b1; alu_op = 2'b00; a = 32'd1; b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, in_ready, result, select} !== {1'b1, 1'b0, r, 4'h1}) begin
        n_fail++; $display("FAIL backpressure[%0d]: ov=%b rdy=%b res=%h sel=%h required 1 0 %h 1",
                           i, out_valid, in_ready, result, select, r);
      end
    end
    in_valid = 1'b0;
    @(negedge clk); out_ready = 1'b1;
  endtask

  task automatic test_rst_mid_div();
    int n = 0; int seen = 0; int lat;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    alu_op = 2'b10; funct = 6'h1A; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_div: ov=%b rdy=%b required 0 0", out_valid, in_ready);
    end
    @(negedge clk); rst = 1'b0;
    m_hi = 0; m_lo = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (out_valid) seen++; end
    n_checks++;
    if (seen != 0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_abort_idle: out_valid_cycles=%0d rdy=%b required 0 1", seen, in_ready);
    end
    issue(2'b10, 6'h10, 32'h0, 32'h0, lat);
    n_checks++;
    if (result !== 32'h0) begin n_fail++; $display("FAIL rst_hi_cleared: got %h required 0", result); end
    issue(2'b10, 6'h12, 32'h0, 32'h0, lat);
    n_checks++;
    if (result !== 32'h0) begin n_fail++; $display("FAIL rst_lo_cleared: got %h required 0", result); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_muldiv();
    test_illegal();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_rst_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
